// File: rtl/alu_exec_pkg.sv
// Shared opcodes, one-hot op-select indices and FSM states for the execute ALU.
// No logic; imported by the decoder, the top level and the bench.
package alu_exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1001;

  localparam int NUM_OPS = 11;

  // Bit positions inside the one-hot op select.
  typedef enum logic [3:0] {
    SEL_ADD, SEL_SUB, SEL_SLL, SEL_SLT, SEL_SLTU, SEL_XOR,
    SEL_SRL, SEL_SRA, SEL_OR, SEL_AND, SEL_MUL
  } op_idx_t;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between operand fetch, the execute ALU and writeback.
// master = producer/consumer side, slave = the ALU.
interface alu_exec_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       instruction_bits;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, instruction_bits, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow, illegal, busy
  );

  modport slave (
    input  in_valid, instruction_bits, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow, illegal, busy
  );

endinterface

// File: rtl/alu_op_decode.sv
// Purpose: map {funct7[5], funct3} to a one-hot op select plus an illegal flag.
// Latency: combinational.
// Backpressure: none; pure decode.
module alu_op_decode
  import alu_exec_pkg::*;
(
  input  logic [3:0]         instruction_bits,
  output logic [NUM_OPS-1:0] op_sel,
  output logic               illegal
);

  always_comb begin
    op_sel  = '0;
    illegal = 1'b0;
    case (instruction_bits)
      OP_ADD:  op_sel[SEL_ADD]  = 1'b1;
      OP_SUB:  op_sel[SEL_SUB]  = 1'b1;
      OP_SLL:  op_sel[SEL_SLL]  = 1'b1;
      OP_SLT:  op_sel[SEL_SLT]  = 1'b1;
      OP_SLTU: op_sel[SEL_SLTU] = 1'b1;
      OP_XOR:  op_sel[SEL_XOR]  = 1'b1;
      OP_SRL:  op_sel[SEL_SRL]  = 1'b1;
      OP_SRA:  op_sel[SEL_SRA]  = 1'b1;
      OP_OR:   op_sel[SEL_OR]   = 1'b1;
      OP_AND:  op_sel[SEL_AND]  = 1'b1;
      OP_MUL:  op_sel[SEL_MUL]  = 1'b1;
      default: illegal          = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Purpose: handshaked execute-stage ALU, RV32I-style integer ops plus shift-add MUL.
// Latency: 1 cycle for single-cycle and illegal ops, WIDTH cycles for MUL.
// Backpressure: in_ready drops while MUL runs or a held result is not taken.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  io
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand, mplier, acc, acc_nxt;
  logic               out_vld;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q, carry_q, ovf_q, ill_q;

  logic [NUM_OPS-1:0] op_sel;
  logic               dec_illegal;
  logic               can_load, accept;
  logic [WIDTH:0]     sum, diff;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_o;

  alu_op_decode u_dec (
    .instruction_bits (io.instruction_bits),
    .op_sel           (op_sel),
    .illegal          (dec_illegal)
  );

  assign can_load = !out_vld || io.out_ready;
  assign accept   = io.in_valid && io.in_ready;

  assign sum   = {1'b0, io.a} + {1'b0, io.b};
  assign diff  = {1'b0, io.a} - {1'b0, io.b};
  assign shamt = io.b[SHW-1:0];

  // MUL and illegal opcodes fall through to a zero result here.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    if (op_sel[SEL_ADD]) begin
      alu_res = sum[WIDTH-1:0];
      alu_c   = sum[WIDTH];
      alu_o   = (io.a[MSB] == io.b[MSB]) && (sum[MSB] != io.a[MSB]);
    end
    if (op_sel[SEL_SUB]) begin
      alu_res = diff[WIDTH-1:0];
      alu_c   = !diff[WIDTH];
      alu_o   = (io.a[MSB] != io.b[MSB]) && (diff[MSB] != io.a[MSB]);
    end
    if (op_sel[SEL_SLL])  alu_res = io.a << shamt;
    if (op_sel[SEL_SRL])  alu_res = io.a >> shamt;
    if (op_sel[SEL_SRA])  alu_res = $signed(io.a) >>> shamt;
    if (op_sel[SEL_SLT])  alu_res = {{(WIDTH-1){1'b0}}, ($signed(io.a) < $signed(io.b))};
    if (op_sel[SEL_SLTU]) alu_res = {{(WIDTH-1){1'b0}}, (io.a < io.b)};
    if (op_sel[SEL_XOR])  alu_res = io.a ^ io.b;
    if (op_sel[SEL_OR])   alu_res = io.a | io.b;
    if (op_sel[SEL_AND])  alu_res = io.a & io.b;
  end

  // Once saturated the multiplier is all zeros, so acc_nxt == acc.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      out_vld <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && op_sel[SEL_MUL]) begin
            state   <= ST_MUL;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= io.a;
            mplier  <= io.b;
            out_vld <= 1'b0;
          end else if (accept) begin
            out_vld <= 1'b1;
            res_q   <= alu_res;
            zero_q  <= (alu_res == '0);
            carry_q <= alu_c;
            ovf_q   <= alu_o;
            ill_q   <= dec_illegal;
          end else if (io.out_ready) begin
            out_vld <= 1'b0;
          end
        end
        ST_MUL: begin
          if (cnt != CNT_MAX) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
          // Final iteration loads the output directly, or later once the slot frees.
          if ((cnt == CNT_LAST || cnt == CNT_MAX) && can_load) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            out_vld <= 1'b1;
            res_q   <= acc_nxt;
            zero_q  <= (acc_nxt == '0);
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
          end else if (io.out_ready) begin
            out_vld <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == ST_IDLE) && can_load;
  assign io.out_valid = out_vld;
  assign io.result    = res_q;
  assign io.zero      = zero_q;
  assign io.carry     = carry_q;
  assign io.overflow  = ovf_q;
  assign io.illegal   = ill_q;
  assign io.busy      = (state == ST_MUL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector scoreboard bench for alu_exec_unit at WIDTH=16.
// Stimulus pushes expected tuples; a negedge monitor pops on each output handshake.
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [3:0]  zcoi;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;
  exp_t sb[$];

  alu_exec_if #(.WIDTH(16)) io ();

  alu_exec_unit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive a request until accepted; queue the expected tuple at the accepting edge.
  task automatic issue(input string nm, input logic [3:0] op, input logic [15:0] av,
                       input logic [15:0] bv, input logic [15:0] res, input logic [3:0] zcoi,
                       input bit is_mul, input bit chk_lat);
    exp_t e;
    int   w = 0;
    io.in_valid = 1'b1;
    io.instruction_bits = op;
    io.a = av;
    io.b = bv;
    @(negedge clk);
    while (!io.in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!io.in_ready) begin
      n_vec++;
      n_mis++;
      $display("FAIL %s_accept: in_ready never rose within 100 cycles", nm);
      io.in_valid = 1'b0;
      return;
    end
    e.name = nm;
    e.res = res;
    e.zcoi = zcoi;
    e.cyc = cyc + 1 + (is_mul ? 16 : 0);
    e.chk_lat = chk_lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.a = ~av;
    io.b = ~bv;
    io.instruction_bits = 4'b1111;
  endtask

  always @(negedge clk) begin
    if (rst_n && io.out_valid && io.out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_out: result %h with empty scoreboard", io.result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_out"},
            {12'd0, io.result, io.zero, io.carry, io.overflow, io.illegal},
            {12'd0, e.res, e.zcoi});
        if (e.chk_lat) chk({e.name, "_lat"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic saw_vld;
    rst_n = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    io.instruction_bits = 4'b0000;
    io.a = '0;
    io.b = '0;
    #2;
    chk("rst_outputs", {8'd0, io.out_valid, io.result, io.zero, io.carry, io.overflow,
                        io.illegal, io.busy}, 32'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, io.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops; zcoi = {zero, carry, overflow, illegal}.
    issue("add_1_2",   OP_ADD,  16'h0001, 16'h0002, 16'h0003, 4'b0000, 0, 1);
    issue("sub_1_2",   OP_SUB,  16'h0001, 16'h0002, 16'hFFFF, 4'b0000, 0, 1);
    issue("and_1_2",   OP_AND,  16'h0001, 16'h0002, 16'h0000, 4'b1000, 0, 1);
    issue("or_1_2",    OP_OR,   16'h0001, 16'h0002, 16'h0003, 4'b0000, 0, 1);
    issue("add_ovf",   OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b0010, 0, 1);
    issue("add_carry", OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 0, 1);
    issue("sra",       OP_SRA,  16'h8001, 16'h0004, 16'hF800, 4'b0000, 0, 1);
    issue("srl",       OP_SRL,  16'h8001, 16'h0004, 16'h0800, 4'b0000, 0, 1);
    issue("sll",       OP_SLL,  16'h8001, 16'h0004, 16'h0010, 4'b0000, 0, 1);
    issue("slt",       OP_SLT,  16'h8000, 16'h0001, 16'h0001, 4'b0000, 0, 1);
    issue("sltu",      OP_SLTU, 16'h8000, 16'h0001, 16'h0000, 4'b1000, 0, 1);
    issue("sub_nobrw", OP_SUB,  16'h0005, 16'h0003, 16'h0002, 4'b0100, 0, 1);
    issue("sub_ovf",   OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0110, 0, 1);
    issue("sll_hib",   OP_SLL,  16'h0001, 16'h0013, 16'h0008, 4'b0000, 0, 1);
    issue("xor",       OP_XOR,  16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000, 0, 1);
    issue("ill_1010",  4'b1010, 16'h0005, 16'h0003, 16'h0000, 4'b1001, 0, 1);

    // Multiply: busy high and in_ready low for all 16 cycles.
    issue("mul_300", OP_MUL, 16'd300, 16'd300, 16'h5F90, 4'b0000, 1, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_%0d", i), {30'd0, io.busy, io.in_ready}, 32'h2);
    end
    repeat (3) @(negedge clk);

    // Backpressure: result held, in_ready low, pending request refused.
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    issue("bp_add", OP_ADD, 16'h1234, 16'h0101, 16'h1335, 4'b0000, 0, 0);
    io.in_valid = 1'b1;
    io.instruction_bits = OP_XOR;
    io.a = 16'h00FF;
    io.b = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_%0d", i),
          {10'd0, io.out_valid, io.in_ready, io.result, io.zero, io.carry, io.overflow, io.illegal},
          {10'd0, 1'b1, 1'b0, 16'h1335, 4'b0000});
    end
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    issue("bp_xor", OP_XOR, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000, 0, 1);
    issue("ill_1111", 4'b1111, 16'h1234, 16'h5678, 16'h0000, 4'b1001, 0, 1);
    issue("mul_pre", OP_MUL, 16'd300, 16'd300, 16'h5F90, 4'b0000, 1, 1);
    repeat (20) @(negedge clk);

    // Reset after 7 multiply iterations: outputs clear, nothing is emitted.
    @(posedge clk);
    #1;
    issue("mul_abort", OP_MUL, 16'd300, 16'd300, 16'h5F90, 4'b0000, 1, 1);
    void'(sb.pop_back());
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mul", {8'd0, io.out_valid, io.result, io.zero, io.carry, io.overflow,
                        io.illegal, io.busy}, 32'd0);
    #10 rst_n = 1'b1;
    saw_vld = 1'b0;
    @(negedge clk);
    chk("rst_rel_in_ready", {31'd0, io.in_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      saw_vld = saw_vld | io.out_valid;
      @(negedge clk);
    end
    chk("rst_no_vld", {31'd0, saw_vld}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
